// File: rtl/cm0_dap_ap_seq_pkg.sv
// cm0_dap_ap_seq_pkg: shared state encoding and bus widths for the AP-domain sequencer
package cm0_dap_ap_seq_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPEN   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4,
        ST_ACK    = 3'd5,
        ST_SETTLE = 3'd6
    } state_t;
    function automatic logic in_access(state_t s);
        return s == ST_ISSUE || s == ST_WAIT;
    endfunction
endpackage

// File: rtl/cm0_dap_ap_seq_if.sv
// cm0_dap_ap_seq_if: AP register/bus access port between the sequencer and the AP
interface cm0_dap_ap_seq_if;
    import cm0_dap_ap_seq_pkg::*;
    logic              acc_req_o;
    logic              acc_write_o;
    logic [ADDR_W-1:0] acc_addr_o;
    logic [DATA_W-1:0] acc_wdata_o;
    logic [DATA_W-1:0] acc_rdata_i;
    logic              acc_err_i;
    logic              acc_done_i;
    modport master(output acc_req_o, acc_write_o, acc_addr_o, acc_wdata_o,
                   input acc_rdata_i, acc_err_i, acc_done_i);
    modport slave(input acc_req_o, acc_write_o, acc_addr_o, acc_wdata_o,
                  output acc_rdata_i, acc_err_i, acc_done_i);
endinterface

// File: rtl/cm0_dap_ap_seq_tmo.sv
// cm0_dap_ap_seq_tmo: clear/enable saturating access-timeout counter with expiry flag
module cm0_dap_ap_seq_tmo #(
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic dclk,
    input  logic apreset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [TMO_W-1:0] cnt;
    // count access cycles from zero, sticking at all-ones so it never wraps back
    always_ff @(posedge dclk or negedge apreset_n)
        if (!apreset_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && cnt != '1) cnt <= cnt + 1'b1;
    assign expired = cnt == TMO_W'(TMO_MAX);
endmodule

// File: rtl/cm0_dap_ap_seq.sv
// cm0_dap_ap_seq: AP-domain sequencer serving one DP request per handshake toggle
module cm0_dap_ap_seq
    import cm0_dap_ap_seq_pkg::*;
#(
    parameter bit PRESENT = 1'b1,
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic              dclk,
    input  logic              apreset_n,
    input  logic              dp_req_ap_i,
    input  logic              ap_ack_ap_i,
    input  logic              dp_rnw_ap_i,
    input  logic [ADDR_W-1:0] dp_regaddr_ap_i,
    input  logic [DATA_W-1:0] dp_data_ap_i,
    output logic              ap_out_en_o,
    output logic              ap_wr_en_o,
    output logic              ap_ack_load_o,
    output logic [DATA_W-1:0] ap_data_ap_o,
    output logic              ap_err_ap_o,
    cm0_dap_ap_seq_if.master  acc
);
    if (PRESENT) begin : g_seq
        state_t            st, nxt;
        logic              out_en, rnw_q, err_q;
        logic [ADDR_W-1:0] addr_q;
        logic [DATA_W-1:0] wdata_q, rdata_q;
        logic              pending, access, finish, tmo_exp;
        assign pending = dp_req_ap_i ^ ap_ack_ap_i;
        assign access  = in_access(st);
        assign finish  = access && nxt == ST_RESP;
        cm0_dap_ap_seq_tmo #(.TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) u_tmo (
            .dclk     (dclk),
            .apreset_n(apreset_n),
            .clr      (st == ST_OPEN),
            .en       (access),
            .expired  (tmo_exp)
        );
        // one pass per request; SETTLE lets the ack level land before pending is looked at again
        always_comb begin
            nxt = st;
            unique case (st)
                ST_IDLE:           nxt = pending ? ST_OPEN : ST_IDLE;
                ST_OPEN:           nxt = ST_ISSUE;
                ST_ISSUE, ST_WAIT: nxt = (acc.acc_done_i || tmo_exp) ? ST_RESP : ST_WAIT;
                ST_RESP:           nxt = ST_ACK;
                ST_ACK:            nxt = ST_SETTLE;
                default:           nxt = ST_IDLE;
            endcase
        end
        // state and the registered crossing mask, high exactly while in OPEN
        always_ff @(posedge dclk or negedge apreset_n)
            if (!apreset_n) begin
                st     <= ST_IDLE;
                out_en <= 1'b0;
            end else begin
                st     <= nxt;
                out_en <= nxt == ST_OPEN;
            end
        // capture the masked DP request while the mask is open
        always_ff @(posedge dclk or negedge apreset_n)
            if (!apreset_n) {rnw_q, addr_q, wdata_q} <= '0;
            else if (st == ST_OPEN) {rnw_q, addr_q, wdata_q} <= {dp_rnw_ap_i, dp_regaddr_ap_i, dp_data_ap_i};
        // return registers: read data only on reads, forced error with zero data on timeout
        always_ff @(posedge dclk or negedge apreset_n)
            if (!apreset_n) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end else if (finish) begin
                rdata_q <= (acc.acc_done_i && rnw_q) ? acc.acc_rdata_i : '0;
                err_q   <= acc.acc_done_i ? acc.acc_err_i : 1'b1;
            end
        assign ap_out_en_o     = out_en;
        assign ap_wr_en_o      = st == ST_RESP;
        assign ap_ack_load_o   = st == ST_ACK;
        assign ap_data_ap_o    = rdata_q;
        assign ap_err_ap_o     = err_q;
        assign acc.acc_req_o   = access;
        assign acc.acc_write_o = access && !rnw_q;
        assign acc.acc_addr_o  = access ? addr_q : '0;
        assign acc.acc_wdata_o = access ? wdata_q : '0;
    end else begin : g_absent
        assign ap_out_en_o     = 1'b0;
        assign ap_wr_en_o      = 1'b0;
        assign ap_ack_load_o   = 1'b0;
        assign ap_data_ap_o    = '0;
        assign ap_err_ap_o     = 1'b0;
        assign acc.acc_req_o   = 1'b0;
        assign acc.acc_write_o = 1'b0;
        assign acc.acc_addr_o  = '0;
        assign acc.acc_wdata_o = '0;
    end
endmodule

// File: tb/tb_cm0_dap_ap_seq.sv
// tb_cm0_dap_ap_seq: directed bench with a transaction-timeline model of the AP sequencer
module tb_cm0_dap_ap_seq;
    localparam int TMO_MAX = 15;
    logic        dclk = 1'b0, apreset_n = 1'b0;
    logic        dp_req = 1'b0, ack_q, rnw = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0, data;
    logic        out_en, wr_en, ack_load, err;
    int          tests = 0, fails = 0, cyc = 0;
    // model of the current request: start cycle, access length (ISSUE..last WAIT), fields, results
    int          t_c = -1000, t_l = 0;
    logic        t_rnw = 1'b1, t_err = 1'b0, t_he = 1'b0;
    logic [3:0]  t_addr = '0;
    logic [31:0] t_wdata = '0, t_data = '0, t_hd = '0;
    int          rel, req_len = 0, last_req_len = 0, ack_cyc = -1, open_cyc = -1, tog_cyc = 0, a1 = 0;
    logic        e_req, last_write = 1'b0;
    logic [3:0]  last_addr = '0;
    logic [31:0] last_wdata = '0;

    cm0_dap_ap_seq_if acc_if();

    cm0_dap_ap_seq #(.PRESENT(1'b1), .TMO_W(4), .TMO_MAX(TMO_MAX)) dut (
        .dclk           (dclk),
        .apreset_n      (apreset_n),
        .dp_req_ap_i    (dp_req),
        .ap_ack_ap_i    (ack_q),
        .dp_rnw_ap_i    (rnw),
        .dp_regaddr_ap_i(addr),
        .dp_data_ap_i   (wdata),
        .ap_out_en_o    (out_en),
        .ap_wr_en_o     (wr_en),
        .ap_ack_load_o  (ack_load),
        .ap_data_ap_o   (data),
        .ap_err_ap_o    (err),
        .acc            (acc_if)
    );

    always #5 dclk = ~dclk;
    always @(posedge dclk) cyc <= cyc + 1;
    // acknowledge register of the CDC send side: copies the request level on the load strobe
    always @(posedge dclk or negedge apreset_n)
        if (!apreset_n) ack_q <= 1'b0;
        else if (ack_load) ack_q <= dp_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    assert property (@(posedge dclk) disable iff (!apreset_n) !(out_en && wr_en))
        else begin fails++; $display("FAIL mask_overlap cyc=%0d got=1 exp=0", cyc); end
    assert property (@(posedge dclk) disable iff (!apreset_n) wr_en |=> ack_load)
        else begin fails++; $display("FAIL ack_after_wr cyc=%0d got=0 exp=1", cyc); end

    // every cycle: open 1 cycle, access 1+t_l cycles, response, ack, settle; return data holds
    initial forever begin
        @(negedge dclk);
        #2;
        rel   = cyc - t_c;
        e_req = apreset_n && rel >= 2 && rel <= 2 + t_l;
        chk("ap_out_en", out_en, apreset_n && rel == 1);
        chk("acc_req", acc_if.acc_req_o, e_req);
        chk("acc_write", acc_if.acc_write_o, e_req && !t_rnw);
        chk("acc_addr", acc_if.acc_addr_o, e_req ? t_addr : 4'h0);
        chk("acc_wdata", acc_if.acc_wdata_o, e_req ? t_wdata : 32'h0);
        chk("ap_wr_en", wr_en, apreset_n && rel == 3 + t_l);
        chk("ap_ack_load", ack_load, apreset_n && rel == 4 + t_l);
        chk("ap_data", data, !apreset_n ? 32'h0 : rel >= 3 + t_l ? t_data : t_hd);
        chk("ap_err", err, !apreset_n ? 1'b0 : rel >= 3 + t_l ? t_err : t_he);
        if (acc_if.acc_req_o) begin
            req_len++;
            last_write = acc_if.acc_write_o;
            last_addr  = acc_if.acc_addr_o;
            last_wdata = acc_if.acc_wdata_o;
        end else if (req_len != 0) begin
            last_req_len = req_len;
            req_len = 0;
        end
        if (ack_load) ack_cyc = cyc;
        if (out_en) open_cyc = cyc;
    end

    // present a request as soon as the ack level has followed; dly<0 means the bus never answers
    task automatic start_txn(input logic r, input logic [3:0] a, input logic [31:0] wd,
                             input int dly, input logic [31:0] rd, input logic e);
        @(negedge dclk);
        for (int i = 0; i < 40 && ack_q !== dp_req; i++) @(negedge dclk);
        chk("ack_follow", ack_q, dp_req);
        rnw = r; addr = a; wdata = wd;
        dp_req  = ~dp_req;
        tog_cyc = cyc;
        t_hd = t_data; t_he = t_err;
        t_c  = (cyc > t_c + 6 + t_l) ? cyc : t_c + 6 + t_l;
        t_l  = dly < 0 ? TMO_MAX : dly;
        t_rnw = r; t_addr = a; t_wdata = wd;
        t_data = (dly < 0 || !r) ? 32'h0 : rd;
        t_err  = dly < 0 ? 1'b1 : e;
    endtask

    // done arrives dly cycles after ISSUE; on timeout a late done is thrown in during ACK
    task automatic run_txn(input logic r, input logic [3:0] a, input logic [31:0] wd,
                           input int dly, input logic [31:0] rd, input logic e);
        start_txn(r, a, wd, dly, rd, e);
        while (cyc < t_c + 2 + t_l + (dly < 0 ? 2 : 0)) @(negedge dclk);
        acc_if.acc_done_i = 1'b1; acc_if.acc_rdata_i = rd; acc_if.acc_err_i = e;
        @(negedge dclk);
        acc_if.acc_done_i = 1'b0; acc_if.acc_rdata_i = 32'hDEAD_BEEF; acc_if.acc_err_i = 1'b1;
        while (cyc < t_c + 4 + t_l) @(negedge dclk);
    endtask

    initial begin
        acc_if.acc_done_i = 1'b0; acc_if.acc_rdata_i = 32'hDEAD_BEEF; acc_if.acc_err_i = 1'b1;
        repeat (3) @(negedge dclk);
        #1;
        chk("reset_acc_req", acc_if.acc_req_o, 1'b0);
        chk("reset_data", data, 32'h0);
        apreset_n = 1'b1;
        repeat (2) @(negedge dclk);
        // read, done in the second WAIT cycle
        run_txn(1'b1, 4'hC, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
        #3;
        chk("t1_data", data, 32'hCAFE_F00D);
        chk("t1_err", err, 1'b0);
        chk("t1_req_len", last_req_len, 3);
        chk("t1_addr", last_addr, 4'hC);
        repeat (3) @(negedge dclk);
        // write: no read data returned
        run_txn(1'b0, 4'h4, 32'h1234_5678, 1, 32'h5555_AAAA, 1'b0);
        #3;
        chk("t2_write", last_write, 1'b1);
        chk("t2_wdata", last_wdata, 32'h1234_5678);
        chk("t2_addr", last_addr, 4'h4);
        chk("t2_data", data, 32'h0);
        repeat (3) @(negedge dclk);
        // timeout with a late done afterwards
        run_txn(1'b1, 4'h8, 32'h0, -1, 32'h7777_7777, 1'b0);
        #3;
        chk("t3_req_len", last_req_len, 16);
        chk("t3_err", err, 1'b1);
        chk("t3_data", data, 32'h0);
        repeat (3) @(negedge dclk);
        // done in the very cycle the timeout would fire wins
        run_txn(1'b1, 4'h1, 32'h0, TMO_MAX, 32'h1357_9BDF, 1'b1);
        #3;
        chk("t3b_data", data, 32'h1357_9BDF);
        chk("t3b_err", err, 1'b1);
        repeat (3) @(negedge dclk);
        // zero-wait, then a back-to-back request
        run_txn(1'b1, 4'h2, 32'h0, 0, 32'hA5A5_0001, 1'b0);
        #3;
        chk("t4_latency", ack_cyc - tog_cyc + 1, 5);
        a1 = ack_cyc;
        run_txn(1'b1, 4'h3, 32'h0, 0, 32'h0F0F_F0F0, 1'b1);
        #3;
        chk("t4_b2b_gap", open_cyc - a1, 3);
        chk("t4_data", data, 32'h0F0F_F0F0);
        repeat (3) @(negedge dclk);
        // reset during WAIT
        start_txn(1'b1, 4'h6, 32'h0, -1, 32'h0, 1'b0);
        while (cyc < t_c + 4) @(negedge dclk);
        chk("t5_req_before", acc_if.acc_req_o, 1'b1);
        chk("t5_data_before", data, 32'h0F0F_F0F0);
        #3;
        apreset_n = 1'b0;
        dp_req = 1'b0;
        t_c = -1000; t_l = 0; t_data = '0; t_err = 1'b0; t_hd = '0; t_he = 1'b0;
        #1;
        chk("t5_req_async", acc_if.acc_req_o, 1'b0);
        chk("t5_data_async", data, 32'h0);
        chk("t5_err_async", err, 1'b0);
        repeat (2) @(posedge dclk);
        @(negedge dclk);
        apreset_n = 1'b1;
        run_txn(1'b1, 4'hA, 32'h0, 0, 32'h600D_CAFE, 1'b0);
        #3;
        chk("t5_after_data", data, 32'h600D_CAFE);
        chk("t5_after_addr", last_addr, 4'hA);
        repeat (5) @(negedge dclk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
